// File: rtl/returner_if.sv
// Request/response bundle for the returner: completed requests in, ordered read responses
// and write acks out.
package returner_pkg;
  typedef enum logic {R_READ = 1'b0, R_WRITE = 1'b1} r_type;
endpackage

interface returner_if #(
  parameter int data_width       = 16,
  parameter int read_entries_log = 4
);
  import returner_pkg::*;

  logic                        returner_valid;
  r_type                       returner_type;
  logic [data_width-1:0]       returner_data;
  logic [read_entries_log-1:0] returner_index;

  logic                        rd_resp_valid;
  logic [data_width-1:0]       rd_resp_data;
  logic [read_entries_log-1:0] rd_resp_index;
  logic                        rd_resp_ready;

  logic                        wr_ack_valid;
  logic [read_entries_log-1:0] wr_ack_index;
  logic                        wr_ack_ready;

  logic [read_entries_log-1:0] rd_head_index;
  logic                        err_dup;
  logic                        err_ovf;

  modport master (
    output returner_valid, returner_type, returner_data, returner_index,
    output rd_resp_ready, wr_ack_ready,
    input  rd_resp_valid, rd_resp_data, rd_resp_index,
    input  wr_ack_valid, wr_ack_index, rd_head_index, err_dup, err_ovf
  );

  modport slave (
    input  returner_valid, returner_type, returner_data, returner_index,
    input  rd_resp_ready, wr_ack_ready,
    output rd_resp_valid, rd_resp_data, rd_resp_index,
    output wr_ack_valid, wr_ack_index, rd_head_index, err_dup, err_ovf
  );
endinterface

// File: rtl/returner.sv
// Returns completed requests: reads reordered into index order (2-cycle latency, held under
// rd_resp_ready=0); writes queued in a small ack FIFO, dropped with err_ovf when full.
module returner #(
  parameter int data_width       = 16,
  parameter int read_entries_log = 4,
  parameter int wr_fifo_depth    = 4
) (
  input logic         clk,
  input logic         rst_n,
  returner_if.slave   bus
);
  import returner_pkg::*;

  localparam int RD_DEPTH = 1 << read_entries_log;
  localparam int FAW      = $clog2(wr_fifo_depth);

  typedef logic [read_entries_log-1:0] idx_t;

  // Read reorder buffer
  logic [data_width-1:0] rob_data [RD_DEPTH];
  logic [RD_DEPTH-1:0]   rob_occ;
  idx_t                  head;

  logic                  resp_valid;
  logic [data_width-1:0] resp_data;
  idx_t                  resp_index;
  logic                  dup_q;
  logic                  ovf_q;

  logic rd_req;
  logic rd_store;
  logic rd_dup;
  logic rd_load;

  assign rd_req   = bus.returner_valid && (bus.returner_type == R_READ);
  assign rd_store = rd_req && !rob_occ[bus.returner_index];
  assign rd_dup   = rd_req &&  rob_occ[bus.returner_index];
  // Occupancy is sampled from the register, so a same-cycle arrival at head never bypasses.
  assign rd_load  = rob_occ[head] && (!resp_valid || bus.rd_resp_ready);

  always_ff @(posedge clk) begin
    if (rd_store) rob_data[bus.returner_index] <= bus.returner_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rob_occ    <= '0;
      head       <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_index <= '0;
      dup_q      <= 1'b0;
    end else begin
      if (rd_load) begin
        rob_occ[head] <= 1'b0;
        head          <= head + idx_t'(1);
        resp_valid    <= 1'b1;
        resp_data     <= rob_data[head];
        resp_index    <= head;
      end else if (bus.rd_resp_ready) begin
        resp_valid <= 1'b0;
      end
      if (rd_store) rob_occ[bus.returner_index] <= 1'b1;
      if (rd_dup)   dup_q <= 1'b1;
    end
  end

  // Write-ack FIFO with one extra pointer bit to tell full from empty
  idx_t         wr_mem [wr_fifo_depth];
  logic [FAW:0] wptr;
  logic [FAW:0] rptr;
  logic         fifo_empty;
  logic         fifo_full;
  logic         wr_req;
  logic         wr_pop;
  logic         wr_push;

  assign fifo_empty = (wptr == rptr);
  assign fifo_full  = (wptr[FAW] != rptr[FAW]) && (wptr[FAW-1:0] == rptr[FAW-1:0]);
  assign wr_req     = bus.returner_valid && (bus.returner_type == R_WRITE);
  assign wr_pop     = !fifo_empty && bus.wr_ack_ready;
  assign wr_push    = wr_req && (!fifo_full || wr_pop);

  always_ff @(posedge clk) begin
    if (wr_push) wr_mem[wptr[FAW-1:0]] <= bus.returner_index;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (wr_push) wptr <= wptr + 1'b1;
      if (wr_pop)  rptr <= rptr + 1'b1;
      if (wr_req && fifo_full && !wr_pop) ovf_q <= 1'b1;
    end
  end

  assign bus.rd_resp_valid = resp_valid;
  assign bus.rd_resp_data  = resp_data;
  assign bus.rd_resp_index = resp_index;
  assign bus.wr_ack_valid  = !fifo_empty;
  // Gated so an unreset storage slot never shows on the port
  assign bus.wr_ack_index  = fifo_empty ? '0 : wr_mem[rptr[FAW-1:0]];
  assign bus.rd_head_index = head;
  assign bus.err_dup       = dup_q;
  assign bus.err_ovf       = ovf_q;
endmodule

// File: tb/tb_returner.sv
// Directed bench for returner: scoreboard queues of expected read responses and write acks.
module tb_returner;
  import returner_pkg::*;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;

  returner_if #(.data_width(16), .read_entries_log(4)) bus ();

  returner #(.data_width(16), .read_entries_log(4), .wr_fifo_depth(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: reorder buffer contents and expected outputs
  logic [15:0] m_data [16];
  bit          m_occ  [16];
  int          m_head;
  int          rd_q [$];
  int          wr_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_occ[i] = 0;
    m_head = 0;
    rd_q.delete();
    wr_q.delete();
  endtask

  // Compare any transfer happening at the coming edge, then advance one cycle.
  task automatic tick();
    if (bus.rd_resp_valid === 1'b1 && bus.rd_resp_ready) begin
      if (rd_q.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
      else chk("rd_resp", {12'd0, bus.rd_resp_index, bus.rd_resp_data}, rd_q.pop_front());
    end
    if (wr_q.size() > 0 && bus.wr_ack_ready) begin
      chk("wr_ack", {31'd0, bus.wr_ack_valid}, 32'd1);
      chk("wr_ack_index", {28'd0, bus.wr_ack_index}, wr_q.pop_front());
    end else if (bus.wr_ack_valid === 1'b1 && bus.wr_ack_ready) begin
      chk("wr_unexpected", 32'd1, 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_rd(input int idx, input int data);
    bus.returner_valid = 1'b1;
    bus.returner_type  = R_READ;
    bus.returner_index = idx[3:0];
    bus.returner_data  = data[15:0];
    if (!m_occ[idx]) begin
      m_occ[idx]  = 1;
      m_data[idx] = data[15:0];
    end
    while (m_occ[m_head]) begin
      rd_q.push_back((m_head << 16) | int'(m_data[m_head]));
      m_occ[m_head] = 0;
      m_head = (m_head + 1) % 16;
    end
    tick();
    bus.returner_valid = 1'b0;
  endtask

  task automatic send_wr(input int idx);
    bus.returner_valid = 1'b1;
    bus.returner_type  = R_WRITE;
    bus.returner_index = idx[3:0];
    if (wr_q.size() < 4 || bus.wr_ack_ready) wr_q.push_back(idx);
    tick();
    bus.returner_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (rd_q.size() + wr_q.size()) != 0; i++) tick();
    chk("drain_empty", rd_q.size() + wr_q.size(), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rd_valid"}, {31'd0, bus.rd_resp_valid}, 32'd0);
    chk({tag, "_rd_data"}, {16'd0, bus.rd_resp_data}, 32'd0);
    chk({tag, "_rd_index"}, {28'd0, bus.rd_resp_index}, 32'd0);
    chk({tag, "_wr_valid"}, {31'd0, bus.wr_ack_valid}, 32'd0);
    chk({tag, "_wr_index"}, {28'd0, bus.wr_ack_index}, 32'd0);
    chk({tag, "_head"}, {28'd0, bus.rd_head_index}, 32'd0);
    chk({tag, "_err_dup"}, {31'd0, bus.err_dup}, 32'd0);
    chk({tag, "_err_ovf"}, {31'd0, bus.err_ovf}, 32'd0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    bus.returner_valid = 1'b0;
    #1;
    check_zero(tag);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    model_clear();
    rst_n              = 1'b0;
    bus.returner_valid = 1'b0;
    bus.returner_type  = R_READ;
    bus.returner_data  = '0;
    bus.returner_index = '0;
    bus.rd_resp_ready  = 1'b1;
    bus.wr_ack_ready   = 1'b1;
    #12;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // In-order reads with 2-cycle latency
    send_rd(0, 'hA0);
    chk("inorder_lat1", {31'd0, bus.rd_resp_valid}, 32'd0);
    send_rd(1, 'hA1);
    chk("inorder_lat2", {31'd0, bus.rd_resp_valid}, 32'd1);
    chk("inorder_first_idx", {28'd0, bus.rd_resp_index}, 32'd0);
    send_rd(2, 'hA2);
    drain();
    chk("inorder_head", {28'd0, bus.rd_head_index}, 32'd3);

    // Reverse arrival: nothing leaves until index 0 is in
    do_reset("rst1");
    send_rd(2, 'hC2);
    chk("reorder_wait2", {31'd0, bus.rd_resp_valid}, 32'd0);
    send_rd(1, 'hC1);
    tick();
    chk("reorder_wait1", {31'd0, bus.rd_resp_valid}, 32'd0);
    send_rd(0, 'hC0);
    chk("reorder_no_bypass", {31'd0, bus.rd_resp_valid}, 32'd0);
    tick();
    chk("reorder_out0", {28'd0, bus.rd_resp_index}, 32'd0);
    tick();
    chk("reorder_out1", {28'd0, bus.rd_resp_index}, 32'd1);
    tick();
    chk("reorder_out2", {28'd0, bus.rd_resp_index}, 32'd2);
    drain();

    // Backpressure holds the output register
    do_reset("rst2");
    bus.rd_resp_ready = 1'b0;
    send_rd(0, 'h55);
    send_rd(1, 'h66);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid_held", {31'd0, bus.rd_resp_valid}, 32'd1);
      chk("bp_data_held", {16'd0, bus.rd_resp_data}, 32'h55);
      tick();
    end
    bus.rd_resp_ready = 1'b1;
    tick();
    chk("bp_next_idx", {28'd0, bus.rd_resp_index}, 32'd1);
    chk("bp_next_valid", {31'd0, bus.rd_resp_valid}, 32'd1);
    drain();

    // Head wraps 15 -> 0
    do_reset("rst3");
    for (int i = 0; i < 14; i++) send_rd(i, 'h100 + i);
    drain();
    chk("wrap_head14", {28'd0, bus.rd_head_index}, 32'd14);
    send_rd(14, 'hE14);
    send_rd(15, 'hE15);
    chk("wrap_head15", {28'd0, bus.rd_head_index}, 32'd15);
    send_rd(0, 'hE00);
    chk("wrap_head0", {28'd0, bus.rd_head_index}, 32'd0);
    send_rd(1, 'hE01);
    chk("wrap_head1", {28'd0, bus.rd_head_index}, 32'd1);
    tick();
    chk("wrap_head2", {28'd0, bus.rd_head_index}, 32'd2);
    drain();

    // Write FIFO overflow, then drain in order
    bus.wr_ack_ready = 1'b0;
    send_wr(3);
    chk("wr_visible", {31'd0, bus.wr_ack_valid}, 32'd1);
    chk("wr_ovf_clear", {31'd0, bus.err_ovf}, 32'd0);
    for (int i = 4; i <= 7; i++) send_wr(i);
    chk("wr_ovf_set", {31'd0, bus.err_ovf}, 32'd1);
    chk("wr_head_idx", {28'd0, bus.wr_ack_index}, 32'd3);
    bus.wr_ack_ready = 1'b1;
    drain();
    chk("wr_empty", {31'd0, bus.wr_ack_valid}, 32'd0);

    // Full FIFO with simultaneous pop accepts the push
    bus.wr_ack_ready = 1'b0;
    for (int i = 8; i <= 11; i++) send_wr(i);
    bus.wr_ack_ready = 1'b1;
    send_wr(12);
    drain();
    chk("wr_ovf_sticky", {31'd0, bus.err_ovf}, 32'd1);

    // Duplicate read keeps first data
    do_reset("rst4");
    send_rd(4, 'h11);
    send_rd(4, 'h22);
    chk("dup_flag", {31'd0, bus.err_dup}, 32'd1);
    for (int i = 0; i < 4; i++) send_rd(i, 'h40 + i);
    drain();
    chk("dup_sticky", {31'd0, bus.err_dup}, 32'd1);
    chk("dup_head", {28'd0, bus.rd_head_index}, 32'd5);

    // Reset mid-transfer discards everything
    bus.rd_resp_ready = 1'b0;
    bus.wr_ack_ready  = 1'b0;
    send_rd(5, 'h77);
    send_rd(6, 'h78);
    send_wr(9);
    tick();
    chk("pre_rst_valid", {31'd0, bus.rd_resp_valid}, 32'd1);
    do_reset("rst5");
    bus.rd_resp_ready = 1'b1;
    bus.wr_ack_ready  = 1'b1;
    tick();
    chk("post_rst_rd", {31'd0, bus.rd_resp_valid}, 32'd0);
    chk("post_rst_wr", {31'd0, bus.wr_ack_valid}, 32'd0);
    chk("post_rst_head", {28'd0, bus.rd_head_index}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
